moore_pattern_tx: RTL and testbench
===================================

MOORE_PATTERN_TX -- requirements
Module: moore_pattern_tx

Interface
REQ-001 The block SHALL expose parameter PAT_W, default 4, meaning pattern length in bits.
REQ-002 The block SHALL expose parameter CNT_W, default 4, meaning repetition-count width.
REQ-003 The block SHALL expose parameter DEF_PAT, default 4'b1010, meaning the pattern latched when pat is all-zero at start.
REQ-004 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 The block SHALL have port pat  input  PAT_W  pattern to transmit, MSB first.
REQ-008 The block SHALL have port reps  input  CNT_W  number of pattern repetitions per burst.
REQ-009 The block SHALL have port dout  output  1  serial data bit, registered.
REQ-010 The block SHALL have port valid  output  1  dout carries a pattern bit this cycle.
REQ-011 The block SHALL have port busy  output  1  burst in progress; start ignored.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse after the last bit of a burst.

Function
REQ-013 The block SHALL be a Moore FSM; all outputs SHALL be registered functions of state only.
REQ-014 States SHALL be IDLE, SHIFT, GAP (present only with the macro) and DONE.
REQ-015 In IDLE: dout=0, valid=0, busy=0, done=0.
REQ-016 IDLE->SHIFT SHALL occur when start=1 and reps!=0; pat (or DEF_PAT if pat==0) and reps SHALL be latched on that edge.
REQ-017 start=1 with reps==0 SHALL be ignored; the FSM SHALL remain in IDLE with no output activity.
REQ-018 The first bit SHALL appear on dout with valid=1 in the cycle after the start-sampling edge (latency 1).
REQ-019 In SHIFT: valid=1, busy=1, dout = latched pattern bit, MSB first, one bit per cycle.
REQ-020 After bit 0 of a repetition, the bit index SHALL wrap to PAT_W-1 and the remaining-repetition counter SHALL decrement.
REQ-021 After bit 0 of the final repetition, the FSM SHALL enter DONE; total valid cycles SHALL be exactly PAT_W*reps.
REQ-022 In DONE: done=1, busy=0, valid=0, dout=0, for exactly one cycle, then IDLE.
REQ-023 start, pat and reps SHALL be ignored in SHIFT, GAP and DONE; latched values SHALL NOT change mid-burst.
REQ-024 start held high continuously SHALL begin a new burst only on the first IDLE cycle after DONE.
REQ-025 Maximum burst (reps=2^CNT_W-1) SHALL complete without counter overflow.

Reset
REQ-026 When reset=0 at a rising clk edge, the FSM SHALL enter IDLE and dout, valid, busy, done SHALL be 0 on the next cycle.
REQ-027 Reset asserted mid-burst SHALL abort the burst without a done pulse; internal counters and latched pattern SHALL clear to 0.
REQ-028 Reset SHALL take priority over start on the same edge.

Configuration
REQ-029 Macro MOORE_PATTERN_TX_GAP_EN SHALL, when defined, compile in state GAP: one cycle between consecutive repetitions with dout=0, valid=0, busy=1.
REQ-030 Without MOORE_PATTERN_TX_GAP_EN, repetitions SHALL be back-to-back with no idle cycle and GAP SHALL not exist.
REQ-031 With the macro, no GAP SHALL follow the final repetition; burst length SHALL be PAT_W*reps + (reps-1) cycles.

Verification
REQ-032 Reset low 2 cycles, then high -> dout=0, valid=0, busy=0, done=0 until start.
REQ-033 start pulse, pat=4'b1010, reps=1 -> dout 1,0,1,0 with valid=1 on cycles 1-4, done=1 on cycle 5, IDLE on cycle 6.
REQ-034 pat=4'b0000, reps=3, macro off -> dout 101010101010 over 12 consecutive valid cycles, then done pulse.
REQ-035 reps=0 with start=1 -> no valid, busy or done for 10 cycles; start during SHIFT with pat=4'b1111 -> original burst unaltered.
REQ-036 reset=0 at bit 2 of a reps=2 burst -> next cycle all outputs 0, no done pulse; new start then transmits a full burst.
REQ-037 Macro defined, pat=4'b1100, reps=2 -> dout/valid sequence 1100, one valid=0 gap cycle, 1100, then done.

Source files
------------

// File: rtl/moore_pattern_tx.sv
// Moore-style serial pattern transmitter: sends a latched pattern MSB first, `reps` times per burst.
// Optional inter-repetition gap cycle is compiled in with `define MOORE_PATTERN_TX_GAP_EN.
module moore_pattern_tx #(
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1010)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [CNT_W-1:0] reps,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    IdxW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(PAT_W - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
`ifdef MOORE_PATTERN_TX_GAP_EN
    StGap   = 2'd2,
`endif
    StDone  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             dout_d, valid_d, busy_d, done_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start && (reps != '0)) begin
          state_d = StShift;
          pat_d   = (pat == '0) ? DEF_PAT : pat;
          rep_d   = reps;
          idx_d   = IdxTop;
        end
      end
      StShift: begin
        if (idx_q == '0) begin
          idx_d = IdxTop;
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = StDone;
          end else begin
`ifdef MOORE_PATTERN_TX_GAP_EN
            state_d = StGap;
`else
            state_d = StShift;
`endif
          end
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
`ifdef MOORE_PATTERN_TX_GAP_EN
      StGap:   state_d = StShift;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they follow state with no comb path.
  always_comb begin
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (state_d == StShift) begin
      dout_d  = pat_d[idx_d];
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end
`ifdef MOORE_PATTERN_TX_GAP_EN
    if (state_d == StGap) begin
      busy_d = 1'b1;
    end
`endif
    if (state_d == StDone) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      pat_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      dout    <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      dout    <= dout_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Self-checking bench for moore_pattern_tx: randomized bursts against a per-cycle expected-output model.
module tb_moore_pattern_tx;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] pat, reps;
  logic       dout, valid, busy, done;
  logic [3:0] obs;
  logic [3:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  assign obs = {dout, valid, busy, done};

  moore_pattern_tx #(
    .PAT_W  (4),
    .CNT_W  (4),
    .DEF_PAT(4'b1010)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .pat  (pat),
    .reps (reps),
    .dout (dout),
    .valid(valid),
    .busy (busy),
    .done (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {dout,valid,busy,done} per cycle, starting one cycle after the start edge.
  task automatic push_burst(input logic [3:0] p, input logic [3:0] r);
    logic [3:0] eff;
    eff = (p == 4'b0000) ? 4'b1010 : p;
    for (int k = 0; k < int'(r); k++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({eff[b], 1'b1, 1'b1, 1'b0});
`ifdef MOORE_PATTERN_TX_GAP_EN
      if (k != int'(r) - 1) exp_q.push_back(4'b0010);
`endif
    end
    exp_q.push_back(4'b0001);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pat = 4'h0; reps = 4'h0;
    step(); step();
    tests++;
    if (obs !== 4'b0000) begin
      fails++; $display("FAIL reset_hold: got %b want 0000", obs);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (obs !== 4'b0000) begin
        fails++; $display("FAIL reset_idle cyc%0d: got %b want 0000", i, obs);
      end
    end
  endtask

  task automatic test_bursts();
    logic [3:0] ps[$];
    logic [3:0] rs[$];
    int         j;
    ps = '{4'b1010, 4'b0000, 4'($urandom)};
    rs = '{4'd1, 4'd3, 4'd15};
    for (int i = 0; i < 6; i++) begin
      ps.push_back(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom));
      rs.push_back(4'($urandom_range(1, 5)));
    end
    for (int i = 0; i < ps.size(); i++) begin
      exp_q.delete();
      push_burst(ps[i], rs[i]);
      pat = ps[i]; reps = rs[i]; start = 1'b1;
      step();
      start = 1'b0; pat = 4'($urandom); reps = 4'($urandom);
      j = 0;
      foreach (exp_q[k]) begin
        tests++;
        if (obs !== exp_q[k]) begin
          fails++;
          $display("FAIL burst%0d pat=%b reps=%0d cyc%0d: got %b want %b",
                   i, ps[i], rs[i], j, obs, exp_q[k]);
        end
        j++;
        step();
      end
      tests++;
      if (obs !== 4'b0000) begin
        fails++; $display("FAIL burst%0d after_done: got %b want 0000", i, obs);
      end
    end
  endtask

  task automatic test_reps_zero();
    pat = 4'($urandom); reps = 4'd0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (obs !== 4'b0000) begin
        fails++; $display("FAIL reps_zero cyc%0d: got %b want 0000", i, obs);
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_ignore_midburst();
    logic [3:0] p;
    int         j;
    p = 4'($urandom_range(1, 14));
    exp_q.delete();
    push_burst(p, 4'd2);
    pat = p; reps = 4'd2; start = 1'b1;
    step();
    j = 0;
    foreach (exp_q[k]) begin
      tests++;
      if (obs !== exp_q[k]) begin
        fails++; $display("FAIL ignore_mid cyc%0d: got %b want %b", j, obs, exp_q[k]);
      end
      j++;
      pat   = 4'b1111;
      reps  = 4'($urandom);
      start = (exp_q[k] == 4'b0001) ? 1'b0 : 1'($urandom);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (obs !== 4'b0000) begin
        fails++; $display("FAIL ignore_mid idle%0d: got %b want 0000", i, obs);
      end
      step();
    end
  endtask

  task automatic test_reset_midburst();
    logic [3:0] p;
    int         j;
    p = 4'($urandom);
    exp_q.delete();
    push_burst(p, 4'd2);
    pat = p; reps = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (obs !== exp_q[i]) begin
        fails++; $display("FAIL rst_mid pre%0d: got %b want %b", i, obs, exp_q[i]);
      end
      if (i == 0) step();
    end
    // Reset on the bit-2 cycle, with a competing start request on the same edge.
    reset = 1'b0; start = 1'b1; reps = 4'd3;
    step();
    tests++;
    if (obs !== 4'b0000) begin
      fails++; $display("FAIL rst_mid abort: got %b want 0000", obs);
    end
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (obs !== 4'b0000) begin
        fails++; $display("FAIL rst_mid no_done%0d: got %b want 0000", i, obs);
      end
    end
    p = 4'($urandom);
    exp_q.delete();
    push_burst(p, 4'd2);
    pat = p; reps = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    j = 0;
    foreach (exp_q[k]) begin
      tests++;
      if (obs !== exp_q[k]) begin
        fails++; $display("FAIL rst_mid reburst cyc%0d: got %b want %b", j, obs, exp_q[k]);
      end
      j++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] p, r;
    int         j;
    p = 4'($urandom);
    r = 4'($urandom_range(1, 3));
    exp_q.delete();
    push_burst(p, r);
    exp_q.push_back(4'b0000);
    push_burst(p, r);
    pat = p; reps = r; start = 1'b1;
    step();
    j = 0;
    foreach (exp_q[k]) begin
      tests++;
      if (obs !== exp_q[k]) begin
        fails++; $display("FAIL b2b cyc%0d: got %b want %b", j, obs, exp_q[k]);
      end
      if (k == exp_q.size() - 1) start = 1'b0;
      j++;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (obs !== 4'b0000) begin
        fails++; $display("FAIL b2b idle%0d: got %b want 0000", i, obs);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_bursts();
    test_reps_zero();
    test_ignore_midburst();
    test_reset_midburst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
